mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the multicycle RISC-V core's unified instruction/data port.
//  Accepts one read or write request at a time via a valid/ready handshake.
//  Inserts a programmable number of wait states and returns a registered response.
//  Backed by an internal word-addressed RAM.
//  Sits between the core's address/write-data outputs and its instruction/data capture registers.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words in the backing RAM
//  WAIT_CYCLES  2             extra cycles between request accept and response (0 legal)
//  BASE_ADDR    32'h0000_0000 byte address mapped to word 0
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request
//  req_write  in   1   1 = store, 0 = load/fetch
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data
//  req_strb   in   4   byte-lane enables for stores (bit i -> wdata[8i+7:8i])
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester accepts response
//  rsp_rdata  out  32  load data (0 for stores and errors)
//  rsp_error  out  1   misaligned or out-of-range access
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset (reset==0, async):
//    - state=IDLE, wait counter=0
//    - rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0, req_ready=1 after release
//    - RAM contents are not cleared.
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE:
//    - req_ready=1.
//    - On req_valid&&req_ready: latch addr/write/wdata/strb; load counter=WAIT_CYCLES.
//    - Next state is WAIT if WAIT_CYCLES>0, else RESP.
//  - WAIT:
//    - req_ready=0; counter decrements each cycle.
//    - When counter==1, next state is RESP.
//  - Entry to RESP, one edge only:
//    - Perform the access and register rsp_rdata/rsp_error.
//    - rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
//  - RESP:
//    - rsp_valid=1; rsp_rdata and rsp_error held stable while rsp_ready==0.
//    - On rsp_ready: go to IDLE; rsp_valid=0 next cycle.
//    - No same-cycle re-accept: req_ready is high again one cycle after the response handshake.
//  - Address decode:
//    - offset = req_addr - BASE_ADDR (32-bit, modulo 2^32); word index = offset[31:2].
//    - Error if req_addr[1:0]!=0 or offset >= DEPTH_WORDS*4.
//    - Addresses below BASE_ADDR wrap to a large offset and are therefore errors.
//  - Stores:
//    - Only lanes with req_strb=1 are written.
//    - strb=4'b0000 is a legal no-op that still responds.
//    - rsp_rdata=0.
//  - Loads: rsp_rdata = full 32-bit word; the core performs byte/half extraction.
//  - Error:
//    - No RAM write; rsp_rdata=0; rsp_error=1.
//    - Timing is identical to a good access, so wait states still apply.
//  - Request inputs are ignored outside IDLE.
//    - A request held across the busy window is accepted only once req_ready returns.
//  - Reset mid-operation:
//    - In WAIT, the transaction is aborted and the pending store is never committed.
//    - In RESP, the store is already committed and the response is dropped.
//  - Read-after-write to the same word returns the merged new data.
// TESTING
//  1. Reset with reset=0, then release.
//     -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0.
//  2. WAIT_CYCLES=2: store 0xDEADBEEF, strb=4'hF, to 0x10; then load 0x10.
//     -> each rsp_valid rises 3 cycles after accept; load returns 0xDEADBEEF, rsp_error=0.
//  3. Store 0x000000AA, strb=4'b0001, to 0x10; then load 0x10.
//     -> returns 0xDEADBEAA.
//  4. Load 0x12 (misaligned), and load 0x1000 with DEPTH_WORDS=1024.
//     -> rsp_error=1, rsp_rdata=0, RAM unchanged.
//  5. Hold rsp_ready=0 for 5 cycles in RESP.
//     -> rsp_valid, rsp_rdata, rsp_error stable; req_ready=0 throughout.
//     -> req_ready=1 one cycle after rsp_ready=1.
//  6. Store 0x12345678 to 0x20; assert reset during WAIT; then load 0x20.
//     -> old contents returned; FSM in IDLE immediately after reset assertion.
//     -> WAIT_CYCLES=0 variant: response exactly 1 cycle after accept.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle core's unified port.
// It accepts one request at a time, waits WAIT_CYCLES extra cycles and then
// returns a registered response from an internal word-addressed RAM.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  request present            req_ready  responder can accept
//   req_write  1 = store, 0 = load        req_addr   byte address
//   req_wdata  store data                 req_strb   store byte-lane enables
//   rsp_valid  response present           rsp_ready  requester takes response
//   rsp_rdata  load data (0 on store/err) rsp_error  misaligned/out of range
//   busy       FSM not idle
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]   RANGE_BYTES = (ADDR_W + 1)'(DEPTH_WORDS) * (ADDR_W + 1)'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } req_t;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;
    logic              req_ready_q, rsp_valid_q, busy_q;

    req_t              in_req_c, cur_req_c;
    logic [ADDR_W-1:0] offset_c;
    logic [IDX_W-1:0]  idx_c;
    logic              err_c;
    logic              access_c;
    logic              ram_we_c;

    // In IDLE the access (zero-wait case) must use the live inputs.
    assign in_req_c  = '{write: req_write, addr: req_addr, wdata: req_wdata, strb: req_strb};
    assign cur_req_c = (state_q == S_IDLE) ? in_req_c : req_q;

    // Address decode; addresses below BASE_ADDR wrap to huge offsets.
    assign offset_c = cur_req_c.addr - BASE_ADDR;
    assign idx_c    = offset_c[IDX_W+1:2];
    assign err_c    = (cur_req_c.addr[1:0] != 2'b00) || ({1'b0, offset_c} >= RANGE_BYTES);

    // Next-state and response datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        access_c = 1'b0;
        ram_we_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d = in_req_c;
                    cnt_d = CNT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = S_RESP;
                        access_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_RESP;
                    access_c = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Access happens only on the edge that enters RESP.
        if (access_c) begin
            error_d  = err_c;
            rdata_d  = (!err_c && !cur_req_c.write) ? mem[idx_c] : '0;
            ram_we_c = !err_c && cur_req_c.write;
        end
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            req_ready_q <= (state_d == S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // Backing RAM: byte-lane writes, contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_c && reset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (cur_req_c.strb[b]) begin
                    mem[idx_c][8*b +: 8] <= cur_req_c.wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;
    assign busy      = busy_q;

endmodule
